// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner of the 4-digit 7-seg scanner.
// Optional: SEG_ARB_BLANK_LEADING_ZERO_EN enables leading-zero blanking.
module seg_display_arbiter #(
    parameter int N_REQ       = 3,
    parameter int SCAN_DIV    = 100000,
    parameter int HOLD_FRAMES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  data_flat,
    output logic [N_REQ-1:0]     gnt,
    output logic [15:0]          disp_value,
    output logic                 scan_tick,
    output logic [1:0]           digit_sel,
    output logic                 frame_done,
    output logic [3:0]           blank,
    output logic                 busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN    = 2'd1,
        SWITCH = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    div_q;
    logic [1:0]       digit_q;
    logic [FW-1:0]    frame_cnt_q;
    logic [IW-1:0]    rr_last_q;
    logic [N_REQ-1:0] gnt_q;
    logic [15:0]      disp_q;

    logic             pick_vld;
    logic [IW-1:0]    pick_idx;
    logic [15:0]      pick_data;
    logic [15:0]      owner_data;
    logic             owner_req;
    logic             others_req;
    logic             hold_done;
    logic [N_REQ-1:0] pick_onehot;

    assign scan_tick  = (div_q == CW'(SCAN_DIV - 1));
    assign frame_done = scan_tick && (digit_q == 2'd3);
    assign digit_sel  = digit_q;
    assign gnt        = gnt_q;
    assign disp_value = disp_q;
    assign busy       = (state_q == OWN) || (state_q == SWITCH);

    // Free-running digit divider and digit index, independent of the FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            digit_q <= 2'd0;
        end else if (scan_tick) begin
            div_q   <= '0;
            digit_q <= digit_q + 2'd1;
        end else begin
            div_q   <= div_q + CW'(1);
        end
    end

    // Round-robin search starting just after the last winner
    always_comb begin
        int idx;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(rr_last_q) + k) % N_REQ;
            if (!pick_vld && req[idx]) begin
                pick_vld = 1'b1;
                pick_idx = idx[IW-1:0];
            end
        end
    end

    assign pick_data   = data_flat[16*int'(pick_idx) +: 16];
    assign owner_data  = data_flat[16*int'(rr_last_q) +: 16];
    assign owner_req   = req[rr_last_q];
    assign others_req  = |(req & ~gnt_q);
    assign hold_done   = (frame_cnt_q == FW'(HOLD_FRAMES - 1));
    assign pick_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;

    // Ownership FSM; grant and displayed value are registered here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            disp_q      <= 16'h0000;
            frame_cnt_q <= '0;
            rr_last_q   <= IW'(N_REQ - 1);
        end else begin
            unique case (state_q)
                IDLE, SWITCH: begin
                    gnt_q <= '0;
                    if (pick_vld) begin
                        state_q     <= OWN;
                        gnt_q       <= pick_onehot;
                        disp_q      <= pick_data;
                        frame_cnt_q <= '0;
                        rr_last_q   <= pick_idx;
                    end else begin
                        state_q <= IDLE;
                        disp_q  <= 16'h0000;
                    end
                end
                OWN: begin
                    if (frame_done) begin
                        disp_q <= owner_data;
                        if (!hold_done)
                            frame_cnt_q <= frame_cnt_q + FW'(1);
                        if (!owner_req || (hold_done && others_req)) begin
                            state_q <= SWITCH;
                            gnt_q   <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    disp_q  <= 16'h0000;
                end
            endcase
        end
    end

`ifdef SEG_ARB_BLANK_LEADING_ZERO_EN
    // Blank each upper digit whose nibble and all higher nibbles are zero
    always_comb begin
        blank    = 4'b0000;
        blank[3] = (disp_q[15:12] == 4'h0);
        blank[2] = blank[3] && (disp_q[11:8] == 4'h0);
        blank[1] = blank[2] && (disp_q[7:4] == 4'h0);
    end
`else
    assign blank = 4'b0000;
`endif

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter (N_REQ=3, SCAN_DIV=4, HOLD=2).
// k counts rising edges since the last reset release; checks at negedge.
module tb_seg_display_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [47:0] data_flat;
    logic [2:0]  gnt;
    logic [15:0] disp_value;
    logic        scan_tick;
    logic [1:0]  digit_sel;
    logic        frame_done;
    logic [3:0]  blank;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int k = 0;

`ifdef SEG_ARB_BLANK_LEADING_ZERO_EN
    localparam logic [3:0] BLK_0000 = 4'b1110;
    localparam logic [3:0] BLK_0042 = 4'b1100;
`else
    localparam logic [3:0] BLK_0000 = 4'b0000;
    localparam logic [3:0] BLK_0042 = 4'b0000;
`endif

    seg_display_arbiter #(
        .N_REQ      (3),
        .SCAN_DIV   (4),
        .HOLD_FRAMES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data_flat (data_flat),
        .gnt       (gnt),
        .disp_value(disp_value),
        .scan_tick (scan_tick),
        .digit_sel (digit_sel),
        .frame_done(frame_done),
        .blank     (blank),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got %h exp %h", tag, k, got, exp);
        end
    endtask

    task automatic go_to(input int t);
        while (k < t) begin
            @(negedge clk);
            k++;
            chk("onehot0", 32'($onehot0(gnt)), 32'd1);
        end
    endtask

    task automatic chk_gnt(input string tag, input logic [2:0] g,
                           input logic [15:0] d, input logic b);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".disp"}, 32'(disp_value), 32'(d));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, ".gnt"}, 32'(gnt), 32'd0);
        chk({tag, ".disp"}, 32'(disp_value), 32'd0);
        chk({tag, ".tick"}, 32'(scan_tick), 32'd0);
        chk({tag, ".dsel"}, 32'(digit_sel), 32'd0);
        chk({tag, ".fdone"}, 32'(frame_done), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        req       = 3'b000;
        data_flat = 48'h0;
        repeat (2) @(negedge clk);
        chk_idle_outs("rst");
        chk("rst.blank", 32'(blank), 32'(BLK_0000));

        // divider only, no requests
        reset = 1'b0;
        k     = 0;
        for (int t = 1; t <= 20; t++) begin
            go_to(t);
            chk("div.tick", 32'(scan_tick), 32'((t % 4) == 3));
            chk("div.dsel", 32'(digit_sel), 32'((t / 4) % 4));
            chk("div.fdone", 32'(frame_done), 32'((t % 16) == 15));
            chk("div.gnt", 32'(gnt), 32'd0);
        end
        chk("div.disp", 32'(disp_value), 32'd0);

        // single requester, 1-cycle grant latency, frame-aligned reload
        data_flat[31:16] = 16'h1234;
        req = 3'b010;
        go_to(21);
        chk_gnt("own1", 3'b010, 16'h1234, 1'b1);
        chk("own1.blank", 32'(blank), 32'd0);
        data_flat[31:16] = 16'hBEEF;
        go_to(30);
        chk("hide.disp", 32'(disp_value), 32'h1234);
        go_to(31);
        chk("hide.fdone", 32'(frame_done), 32'd1);
        chk("hide2.disp", 32'(disp_value), 32'h1234);
        go_to(32);
        chk_gnt("reload", 3'b010, 16'hBEEF, 1'b1);

        // req0 arrives after one frame; preempt only at the second frame_done
        data_flat[15:0] = 16'hA5A5;
        req = 3'b011;
        go_to(47);
        chk("pre.fdone", 32'(frame_done), 32'd1);
        chk_gnt("pre.hold", 3'b010, 16'hBEEF, 1'b1);
        go_to(48);
        chk_gnt("pre.gap", 3'b000, 16'hBEEF, 1'b1);
        go_to(49);
        chk_gnt("pre.new", 3'b001, 16'hA5A5, 1'b1);

        // owner drops mid-frame, nobody else: hold to frame_done then idle
        go_to(52);
        req = 3'b000;
        go_to(63);
        chk_gnt("rel.hold", 3'b001, 16'hA5A5, 1'b1);
        go_to(64);
        chk_gnt("rel.sw", 3'b000, 16'hA5A5, 1'b1);
        go_to(65);
        chk_gnt("rel.idle", 3'b000, 16'h0000, 1'b0);
        chk("rel.blank", 32'(blank), 32'(BLK_0000));

        // asynchronous reset in the middle of an ownership
        req = 3'b010;
        go_to(70);
        chk_gnt("pre_rst", 3'b010, 16'hBEEF, 1'b1);
        chk("pre_rst.dsel", 32'(digit_sel), 32'd1);
        reset = 1'b1;
        #1;
        chk_idle_outs("arst");

        // all three requesting from reset: 0 -> 1 -> 2 -> 0
        req       = 3'b111;
        data_flat = {16'h0042, 16'h2222, 16'h1111};
        @(negedge clk);
        reset = 1'b0;
        k     = 0;
        go_to(1);
        chk_gnt("rr0", 3'b001, 16'h1111, 1'b1);
        go_to(15);
        chk("rr0.f1", 32'(gnt), 32'b001);
        go_to(31);
        chk("rr0.f2", 32'(gnt), 32'b001);
        go_to(32);
        chk_gnt("rr.gap1", 3'b000, 16'h1111, 1'b1);
        go_to(33);
        chk_gnt("rr1", 3'b010, 16'h2222, 1'b1);
        go_to(63);
        chk("rr1.end", 32'(gnt), 32'b010);
        go_to(64);
        chk("rr.gap2", 32'(gnt), 32'b000);
        go_to(65);
        chk_gnt("rr2", 3'b100, 16'h0042, 1'b1);
        chk("rr2.blank", 32'(blank), 32'(BLK_0042));
        go_to(95);
        chk("rr2.end", 32'(gnt), 32'b100);
        go_to(96);
        chk("rr.gap3", 32'(gnt), 32'b000);
        go_to(97);
        chk_gnt("rr0b", 3'b001, 16'h1111, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
